// File: rtl/ibex_irq_ctrl_pkg.sv
// Shared types and constants for the interrupt-source controller: source indices,
// the core-facing irqs_t bundle, trap cause encodings and the cause-to-source map.
package ibex_irq_ctrl_pkg;

    localparam int unsigned IRQ_NUM_SRC  = 19;
    localparam int unsigned IRQ_NUM_FAST = 15;

    localparam logic [4:0] IRQ_IDX_SW    = 5'd0;
    localparam logic [4:0] IRQ_IDX_TIMER = 5'd1;
    localparam logic [4:0] IRQ_IDX_EXT   = 5'd2;
    localparam logic [4:0] IRQ_IDX_FAST0 = 5'd3;
    localparam logic [4:0] IRQ_IDX_NMI   = 5'd18;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef enum logic [5:0] {
        EXC_CAUSE_INSN_ADDR_MISA     = 6'h00,
        EXC_CAUSE_INSTR_ACCESS_FAULT = 6'h01,
        EXC_CAUSE_ILLEGAL_INSN       = 6'h02,
        EXC_CAUSE_BREAKPOINT         = 6'h03,
        EXC_CAUSE_LOAD_ACCESS_FAULT  = 6'h05,
        EXC_CAUSE_STORE_ACCESS_FAULT = 6'h07,
        EXC_CAUSE_ECALL_UMODE        = 6'h08,
        EXC_CAUSE_ECALL_MMODE        = 6'h0B,
        EXC_CAUSE_IRQ_SOFTWARE_M     = 6'h23,
        EXC_CAUSE_IRQ_TIMER_M        = 6'h27,
        EXC_CAUSE_IRQ_EXTERNAL_M     = 6'h2B,
        EXC_CAUSE_IRQ_FAST_0         = 6'h30,
        EXC_CAUSE_IRQ_FAST_14        = 6'h3E,
        EXC_CAUSE_IRQ_NM             = 6'h3F
    } exc_cause_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } irq_idx_t;

    // Only interrupt causes (bit 5 set) map to a source; cause 31 is the NMI.
    function automatic irq_idx_t irq_cause_to_idx(exc_cause_e cause);
        irq_idx_t   res;
        logic [5:0] id;
        id        = cause;
        res.valid = 1'b0;
        res.idx   = 5'd0;
        if (id[5]) begin
            if (id[4]) begin
                res.valid = 1'b1;
                res.idx   = (id[3:0] == 4'hF) ? IRQ_IDX_NMI : (IRQ_IDX_FAST0 + {1'b0, id[3:0]});
            end else if (id[4:0] == 5'd3) begin
                res.valid = 1'b1;
                res.idx   = IRQ_IDX_SW;
            end else if (id[4:0] == 5'd7) begin
                res.valid = 1'b1;
                res.idx   = IRQ_IDX_TIMER;
            end else if (id[4:0] == 5'd11) begin
                res.valid = 1'b1;
                res.idx   = IRQ_IDX_EXT;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_irq_ctrl_sync.sv
// Multi-stage flip-flop synchroniser for a bus of independent single-bit lines,
// cleared asynchronously by an active-low reset.
module ibex_irq_sync #(
    parameter int unsigned Width  = 19,
    parameter int unsigned Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stages_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < Stages; s++) begin
                stages_q[s] <= '0;
            end
        end else begin
            stages_q[0] <= d_i;
            for (int s = 1; s < Stages; s++) begin
                stages_q[s] <= stages_q[s-1];
            end
        end
    end

    assign q_o = stages_q[Stages-1];

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt-source controller: synchronises raw lines, keeps per-source pending state
// and retires edge requests on trap acknowledge. Synchronisers exist only with IBEX_IRQ_CTRL_SYNC_EN.
module ibex_irq_ctrl
    import ibex_irq_ctrl_pkg::*;
#(
    parameter int unsigned           NumFast    = 15,
    parameter int unsigned           SyncStages = 2,
    parameter logic [IRQ_NUM_SRC-1:0] EdgeMask  = 19'h40000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [IRQ_NUM_SRC-1:0] irq_src_i,
    input  logic                   sw_irq_set_i,
    input  logic                   sw_irq_clr_i,
    output irqs_t                  irqs_o,
    output logic                   irq_nm_o,
    input  logic                   irq_ack_i,
    input  logic [5:0]             irq_ack_id_i,
    output logic                   ack_err_o
);

    // The NMI is forced edge-triggered whatever the mask says.
    localparam logic [IRQ_NUM_SRC-1:0] EdgeSel = EdgeMask | (19'b1 << IRQ_IDX_NMI);

    if (NumFast != IRQ_NUM_FAST) begin : g_bad_num_fast
        $error("NumFast must equal the irq_fast width of 15");
    end
    if (SyncStages < 2 || SyncStages > 3) begin : g_bad_sync_stages
        $error("SyncStages must be 2 or 3");
    end

    logic [IRQ_NUM_SRC-1:0] sync;
    logic [IRQ_NUM_SRC-1:0] sync_q;
    logic [IRQ_NUM_SRC-1:0] rise;
    logic [IRQ_NUM_SRC-1:0] ack_hit;
    logic [IRQ_NUM_SRC-1:0] pending_q;
    logic [IRQ_NUM_SRC-1:0] pending_d;
    logic                   ack_err_q;
    logic                   ack_err_d;
    irq_idx_t               ack_map;

`ifdef IBEX_IRQ_CTRL_SYNC_EN
    ibex_irq_sync #(
        .Width  (IRQ_NUM_SRC),
        .Stages (SyncStages)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_src_i),
        .q_o    (sync)
    );
`else
    assign sync = irq_src_i;
`endif

    assign rise    = sync & ~sync_q;
    assign ack_map = irq_cause_to_idx(exc_cause_e'(irq_ack_id_i));

    always_comb begin
        ack_hit = '0;
        if (irq_ack_i && ack_map.valid) begin
            ack_hit[ack_map.idx] = 1'b1;
        end
    end

    // A new rising edge outranks an ack in the same cycle, so the request is never lost.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(IRQ_NUM_SRC); i++) begin
            if (EdgeSel[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~ack_hit[i]);
            end else begin
                pending_d[i] = sync[i];
            end
        end
        pending_d[IRQ_IDX_SW] = ((EdgeSel[IRQ_IDX_SW] ? (pending_q[IRQ_IDX_SW] & ~ack_hit[IRQ_IDX_SW])
                                                      : pending_q[IRQ_IDX_SW])
                                 | sw_irq_set_i
                                 | (EdgeSel[IRQ_IDX_SW] ? rise[IRQ_IDX_SW] : sync[IRQ_IDX_SW]))
                                & ~sw_irq_clr_i;
    end

    assign ack_err_d = ack_err_q | (|(ack_hit & ~pending_q & ~(rise & EdgeSel)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            pending_q <= '0;
            ack_err_q <= 1'b0;
        end else begin
            sync_q    <= sync;
            pending_q <= pending_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign irqs_o.irq_software = pending_q[IRQ_IDX_SW];
    assign irqs_o.irq_timer    = pending_q[IRQ_IDX_TIMER];
    assign irqs_o.irq_external = pending_q[IRQ_IDX_EXT];
    assign irqs_o.irq_fast     = pending_q[IRQ_IDX_FAST0 +: IRQ_NUM_FAST];
    assign irq_nm_o            = pending_q[IRQ_IDX_NMI];
    assign ack_err_o           = ack_err_q;

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Directed self-checking bench for ibex_irq_ctrl; expected latency follows IBEX_IRQ_CTRL_SYNC_EN.
module tb_ibex_irq_ctrl;
    import ibex_irq_ctrl_pkg::*;

    localparam int unsigned SyncStages = 2;
    localparam logic [18:0] EdgeMask   = 19'h40088;
`ifdef IBEX_IRQ_CTRL_SYNC_EN
    localparam int Lat = SyncStages + 1;
`else
    localparam int Lat = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [18:0] irq_src_i;
    logic        sw_irq_set_i;
    logic        sw_irq_clr_i;
    irqs_t       irqs_o;
    logic        irq_nm_o;
    logic        irq_ack_i;
    logic [5:0]  irq_ack_id_i;
    logic        ack_err_o;

    int checks   = 0;
    int failures = 0;

    ibex_irq_ctrl #(
        .NumFast    (15),
        .SyncStages (SyncStages),
        .EdgeMask   (EdgeMask)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .irq_src_i    (irq_src_i),
        .sw_irq_set_i (sw_irq_set_i),
        .sw_irq_clr_i (sw_irq_clr_i),
        .irqs_o       (irqs_o),
        .irq_nm_o     (irq_nm_o),
        .irq_ack_i    (irq_ack_i),
        .irq_ack_id_i (irq_ack_id_i),
        .ack_err_o    (ack_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [18:0] src, input logic set, input logic clr,
                                 input logic ack, input logic [5:0] id);
        irq_src_i    = src;
        sw_irq_set_i = set;
        sw_irq_clr_i = clr;
        irq_ack_i    = ack;
        irq_ack_id_i = id;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(19'h0, 1'b0, 1'b0, 1'b0, 6'h00);
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        $display("[TB] start, source latency %0d edges", Lat);
        rst_ni = 1'b0;
        applyStimulus(19'h0, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(2);
        checkOutput("reset_irqs", 32'(irqs_o), 32'h0);
        checkOutput("reset_nmi", 32'(irq_nm_o), 32'h0);
        checkOutput("reset_err", 32'(ack_err_o), 32'h0);
        rst_ni = 1'b1;
        tick(1);

        // Level timer source
        applyStimulus(19'h00002, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        checkOutput("timer_early", 32'(irqs_o), 32'h0);
        tick(1);
        checkOutput("timer_set", 32'(irqs_o), 32'h10000);
        applyStimulus(19'h00002, 1'b0, 1'b0, 1'b1, 6'h27);
        tick(1);
        applyStimulus(19'h00002, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("timer_ack_ignored", 32'(irqs_o), 32'h10000);
        checkOutput("timer_ack_no_err", 32'(ack_err_o), 32'h0);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        checkOutput("timer_hold", 32'(irqs_o), 32'h10000);
        tick(1);
        checkOutput("timer_drop", 32'(irqs_o), 32'h0);

        // Edge fast[4]: one-cycle pulse, ack clears, repeat ack flags error
        applyStimulus(19'h00080, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        checkOutput("fast4_set", 32'(irqs_o), 32'h00010);
        tick(3);
        checkOutput("fast4_held", 32'(irqs_o), 32'h00010);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b1, 6'h34);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("fast4_ack_clear", 32'(irqs_o), 32'h0);
        checkOutput("fast4_ack_no_err", 32'(ack_err_o), 32'h0);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b1, 6'h34);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("fast4_reack_err", 32'(ack_err_o), 32'h1);
        tick(2);
        checkOutput("err_sticky", 32'(ack_err_o), 32'h1);
        doReset();
        checkOutput("err_cleared", 32'(ack_err_o), 32'h0);

        // NMI: ack coinciding with a new rising edge keeps it pending
        applyStimulus(19'h40000, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        checkOutput("nmi_set", 32'(irq_nm_o), 32'h1);
        tick(Lat + 1);
        applyStimulus(19'h40000, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        applyStimulus(19'h40000, 1'b0, 1'b0, 1'b1, 6'h3F);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("nmi_set_wins", 32'(irq_nm_o), 32'h1);
        checkOutput("nmi_set_wins_no_err", 32'(ack_err_o), 32'h0);
        tick(Lat + 1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b1, 6'h3F);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("nmi_ack_clear", 32'(irq_nm_o), 32'h0);
        checkOutput("nmi_ack_no_err", 32'(ack_err_o), 32'h0);

        // Software pending: set, then set+clear together
        applyStimulus(19'h00000, 1'b1, 1'b0, 1'b0, 6'h00);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("sw_set", 32'(irqs_o), 32'h20000);
        tick(2);
        checkOutput("sw_held", 32'(irqs_o), 32'h20000);
        applyStimulus(19'h00000, 1'b1, 1'b1, 1'b0, 6'h00);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("sw_clr_wins", 32'(irqs_o), 32'h0);

        // Unmapped acks with nothing pending
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b1, 6'h02);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b1, 6'h21);
        tick(1);
        applyStimulus(19'h00000, 1'b0, 1'b0, 1'b0, 6'h00);
        checkOutput("inv_ack_irqs", 32'(irqs_o), 32'h0);
        checkOutput("inv_ack_nmi", 32'(irq_nm_o), 32'h0);
        checkOutput("inv_ack_err", 32'(ack_err_o), 32'h0);

        // Asynchronous reset with fast[0] held high, then re-trigger
        applyStimulus(19'h00008, 1'b1, 1'b0, 1'b0, 6'h00);
        tick(1);
        applyStimulus(19'h00008, 1'b0, 1'b0, 1'b0, 6'h00);
        tick(Lat - 1);
        checkOutput("fast0_set", 32'(irqs_o), 32'h20001);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_irqs", 32'(irqs_o), 32'h0);
        checkOutput("async_rst_nmi", 32'(irq_nm_o), 32'h0);
        tick(2);
        rst_ni = 1'b1;
        tick(Lat - 1);
        checkOutput("fast0_retrig_early", 32'(irqs_o), 32'h0);
        tick(1);
        checkOutput("fast0_retrig", 32'(irqs_o), 32'h00001);
        tick(3);
        checkOutput("fast0_once", 32'(irqs_o), 32'h00001);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
